card_dealer: RTL and testbench

- Consumes the 4-bit rank stream from the upstream LFSR stage (`rnd`, values 1..13 when valid) and deals cards from a finite deck.
- Holds COPIES_PER_RANK copies of each of the 13 ranks.
- Tracks per-rank usage and rejects ranks that are exhausted or out of range.
- Returns one dealt card per request, with its blackjack point value, to the game controller.

---
 rtl/card_dealer.sv | 123 ++++++++++++
 tb/tb_card_dealer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Finite-deck card dealer: filters the LFSR rank stream against per-rank usage
// and returns one dealt card (rank, blackjack value) per request.
module card_dealer #(
  parameter int COPIES_PER_RANK = 4,
  parameter int MAX_TRIES       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       deal_req,
  input  logic [3:0] rnd,
  output logic       busy,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [3:0] card_value,
  output logic       card_is_ace,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       err
);

  localparam logic [5:0] DECK_SIZE = 6'(13 * COPIES_PER_RANK);
  localparam logic [2:0] COPIES    = 3'(COPIES_PER_RANK);
  localparam logic [7:0] LAST_TRY  = 8'(MAX_TRIES - 1);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t     state_q;
  logic [2:0] usage_q [13];
  logic [5:0] cards_left_q;
  logic [7:0] tries_q;
  logic [3:0] card_rank_q;
  logic [3:0] card_value_q;
  logic       card_is_ace_q;
  logic       card_valid_q;
  logic       err_q;

  logic [2:0] sel_cnt;
  logic       in_range;
  logic       accept;

  function automatic logic [3:0] rank_value(input logic [3:0] r);
    if (r == 4'd1)       rank_value = 4'd11;
    else if (r >= 4'd11) rank_value = 4'd10;
    else                 rank_value = r;
  endfunction

  // Usage count of the rank currently offered by the LFSR.
  always_comb begin
    sel_cnt = 3'd0;
    for (int r = 0; r < 13; r++) begin
      if (rnd == 4'(r + 1)) sel_cnt = usage_q[r];
    end
    in_range = (rnd >= 4'd1) && (rnd <= 4'd13);
    accept   = in_range && (sel_cnt < COPIES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      for (int r = 0; r < 13; r++) usage_q[r] <= 3'd0;
      cards_left_q  <= DECK_SIZE;
      tries_q       <= 8'd0;
      card_rank_q   <= 4'd0;
      card_value_q  <= 4'd0;
      card_is_ace_q <= 1'b0;
      card_valid_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      card_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (shuffle) begin
            for (int r = 0; r < 13; r++) usage_q[r] <= 3'd0;
            cards_left_q <= DECK_SIZE;
          end else if (deal_req) begin
            if (deck_empty) begin
              err_q <= 1'b1;
            end else begin
              state_q <= DRAW;
              tries_q <= 8'd0;
            end
          end
        end
        DRAW: begin
          // Shuffle aborts silently; the last dealt card stays on the outputs.
          if (shuffle) begin
            for (int r = 0; r < 13; r++) usage_q[r] <= 3'd0;
            cards_left_q <= DECK_SIZE;
            state_q      <= IDLE;
          end else if (accept) begin
            for (int r = 0; r < 13; r++) begin
              if (rnd == 4'(r + 1)) usage_q[r] <= usage_q[r] + 3'd1;
            end
            cards_left_q  <= cards_left_q - 6'd1;
            card_rank_q   <= rnd;
            card_value_q  <= rank_value(rnd);
            card_is_ace_q <= (rnd == 4'd1);
            card_valid_q  <= 1'b1;
            state_q       <= IDLE;
          end else if (tries_q == LAST_TRY) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            tries_q <= tries_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == DRAW);
  assign card_valid  = card_valid_q;
  assign card_rank   = card_rank_q;
  assign card_value  = card_value_q;
  assign card_is_ace = card_is_ace_q;
  assign cards_left  = cards_left_q;
  assign deck_empty  = (cards_left_q == 6'd0);
  assign err         = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed testbench for card_dealer: reset, deals, rejects, exhaustion,
// empty deck, shuffle interactions, back-to-back and async reset.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       shuffle;
  logic       deal_req;
  logic [3:0] rnd;
  logic       busy;
  logic       card_valid;
  logic [3:0] card_rank;
  logic [3:0] card_value;
  logic       card_is_ace;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       err;

  int checks = 0;
  int errors = 0;

  card_dealer #(.COPIES_PER_RANK(4), .MAX_TRIES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .shuffle    (shuffle),
    .deal_req   (deal_req),
    .rnd        (rnd),
    .busy       (busy),
    .card_valid (card_valid),
    .card_rank  (card_rank),
    .card_value (card_value),
    .card_is_ace(card_is_ace),
    .cards_left (cards_left),
    .deck_empty (deck_empty),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_value(input logic [3:0] r);
    case (r)
      4'd1:  exp_value = 4'd11;
      4'd2:  exp_value = 4'd2;
      4'd3:  exp_value = 4'd3;
      4'd4:  exp_value = 4'd4;
      4'd5:  exp_value = 4'd5;
      4'd6:  exp_value = 4'd6;
      4'd7:  exp_value = 4'd7;
      4'd8:  exp_value = 4'd8;
      4'd9:  exp_value = 4'd9;
      4'd10: exp_value = 4'd10;
      4'd11: exp_value = 4'd10;
      4'd12: exp_value = 4'd10;
      4'd13: exp_value = 4'd10;
      default: exp_value = 4'd0;
    endcase
  endfunction

  // Issues one deal_req pulse with rnd held; reports the first valid/err seen
  // and how many cycles after the DRAW entry it appeared (-1 on timeout).
  task automatic do_deal(input logic [3:0] r, output logic got_v,
                         output logic got_e, output int cyc);
    @(negedge clk); deal_req = 1'b1; rnd = r;
    @(negedge clk); deal_req = 1'b0;
    got_v = 1'b0; got_e = 1'b0; cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (card_valid || err) begin
        got_v = card_valid; got_e = err; cyc = i;
        break;
      end
    end
  endtask

  task automatic do_shuffle();
    @(negedge clk); shuffle = 1'b1;
    @(negedge clk); shuffle = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; shuffle = 1'b0; deal_req = 1'b0; rnd = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (card_rank !== 4'd0) begin errors++; $display("FAIL reset_rank: got %0d want 0", card_rank); end
    checks++; if (card_value !== 4'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", card_value); end
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL reset_left: got %0d want 52", cards_left); end
    checks++; if (deck_empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b want 0", deck_empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (card_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", card_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_deal_basic();
    logic v, e; int cyc;
    do_shuffle();
    do_deal(4'd12, v, e, cyc);
    checks++; if (cyc !== 1 || v !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL basic_latency: got cyc=%0d v=%b e=%b want cyc=1 v=1 e=0", cyc, v, e); end
    checks++; if (card_rank !== 4'd12) begin errors++; $display("FAIL basic_rank: got %0d want 12", card_rank); end
    checks++; if (card_value !== 4'd10) begin errors++; $display("FAIL basic_value: got %0d want 10", card_value); end
    checks++; if (card_is_ace !== 1'b0) begin errors++; $display("FAIL basic_ace: got %b want 0", card_is_ace); end
    checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL basic_left: got %0d want 51", cards_left); end
    @(negedge clk);
    checks++; if (card_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse: got valid=%b busy=%b want 0 0", card_valid, busy); end
  endtask

  task automatic test_reject_range();
    logic bad;
    do_shuffle();
    @(negedge clk); deal_req = 1'b1; rnd = 4'd14;
    @(negedge clk); deal_req = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (card_valid || err || !busy) bad = 1'b1;
    end
    rnd = 4'd1;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL range_reject: got bad=%b want 0", bad); end
    @(negedge clk);
    checks++; if (card_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL range_valid: got v=%b e=%b want 1 0", card_valid, err); end
    checks++; if (card_rank !== 4'd1 || card_value !== 4'd11) begin errors++; $display("FAIL range_ace: got rank=%0d val=%0d want 1 11", card_rank, card_value); end
    checks++; if (card_is_ace !== 1'b1) begin errors++; $display("FAIL range_isace: got %b want 1", card_is_ace); end
    checks++; if (cards_left !== 6'd51) begin errors++; $display("FAIL range_left: got %0d want 51", cards_left); end
  endtask

  task automatic test_exhaust();
    logic v, e; int cyc;
    do_shuffle();
    for (int k = 0; k < 4; k++) begin
      do_deal(4'd5, v, e, cyc);
      checks++; if (v !== 1'b1 || card_rank !== 4'd5) begin errors++; $display("FAIL exhaust_deal%0d: got v=%b rank=%0d want 1 5", k, v, card_rank); end
    end
    checks++; if (cards_left !== 6'd48) begin errors++; $display("FAIL exhaust_left: got %0d want 48", cards_left); end
    do_deal(4'd5, v, e, cyc);
    checks++; if (v !== 1'b0 || e !== 1'b1 || cyc !== 32) begin errors++; $display("FAIL exhaust_err: got v=%b e=%b cyc=%0d want 0 1 32", v, e, cyc); end
    checks++; if (cards_left !== 6'd48 || busy !== 1'b0) begin errors++; $display("FAIL exhaust_hold: got left=%0d busy=%b want 48 0", cards_left, busy); end
    do_shuffle();
    checks++; if (cards_left !== 6'd52) begin errors++; $display("FAIL exhaust_shuffle: got %0d want 52", cards_left); end
  endtask

  task automatic test_empty_deck();
    logic v, e; int cyc;
    int bad_deals;
    do_shuffle();
    bad_deals = 0;
    for (int r = 1; r <= 13; r++) begin
      for (int k = 0; k < 4; k++) begin
        do_deal(4'(r), v, e, cyc);
        if (v !== 1'b1 || card_rank !== 4'(r) || card_value !== exp_value(4'(r))) bad_deals++;
      end
    end
    checks++; if (bad_deals !== 0) begin errors++; $display("FAIL empty_deals: got %0d bad deals want 0", bad_deals); end
    checks++; if (cards_left !== 6'd0 || deck_empty !== 1'b1) begin errors++; $display("FAIL empty_flag: got left=%0d empty=%b want 0 1", cards_left, deck_empty); end
    @(negedge clk); deal_req = 1'b1; rnd = 4'd2;
    @(negedge clk); deal_req = 1'b0;
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL empty_err: got err=%b busy=%b want 1 0", err, busy); end
    @(negedge clk);
    checks++; if (err !== 1'b0 || busy !== 1'b0 || card_valid !== 1'b0) begin errors++; $display("FAIL empty_after: got err=%b busy=%b v=%b want 0 0 0", err, busy, card_valid); end
    do_shuffle();
    checks++; if (deck_empty !== 1'b0 || cards_left !== 6'd52) begin errors++; $display("FAIL empty_refill: got empty=%b left=%0d want 0 52", deck_empty, cards_left); end
  endtask

  task automatic test_shuffle();
    logic v, e; int cyc;
    do_shuffle();
    do_deal(4'd7, v, e, cyc);
    @(negedge clk); shuffle = 1'b1; deal_req = 1'b1; rnd = 4'd3;
    @(negedge clk); shuffle = 1'b0; deal_req = 1'b0;
    checks++; if (busy !== 1'b0 || cards_left !== 6'd52) begin errors++; $display("FAIL shuf_coincident: got busy=%b left=%0d want 0 52", busy, cards_left); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || card_valid !== 1'b0) begin errors++; $display("FAIL shuf_nodraw: got busy=%b v=%b want 0 0", busy, card_valid); end
    do_deal(4'd7, v, e, cyc);
    @(negedge clk); deal_req = 1'b1; rnd = 4'd0;
    @(negedge clk); deal_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL shuf_indraw: got busy=%b want 1", busy); end
    shuffle = 1'b1;
    @(negedge clk); shuffle = 1'b0;
    checks++; if (busy !== 1'b0 || card_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL shuf_abort: got busy=%b v=%b e=%b want 0 0 0", busy, card_valid, err); end
    checks++; if (cards_left !== 6'd52 || card_rank !== 4'd7) begin errors++; $display("FAIL shuf_state: got left=%0d rank=%0d want 52 7", cards_left, card_rank); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    do_shuffle();
    @(negedge clk); deal_req = 1'b1; rnd = 4'd3;
    nvalid = 0;
    repeat (4) begin
      @(negedge clk);
      if (card_valid) nvalid++;
    end
    deal_req = 1'b0;
    checks++; if (nvalid !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", nvalid); end
    checks++; if (cards_left !== 6'd50 || card_rank !== 4'd3) begin errors++; $display("FAIL b2b_left: got left=%0d rank=%0d want 50 3", cards_left, card_rank); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    logic v, e; int cyc;
    do_shuffle();
    do_deal(4'd9, v, e, cyc);
    @(negedge clk); deal_req = 1'b1; rnd = 4'd0;
    @(negedge clk); deal_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || card_rank !== 4'd0 || cards_left !== 6'd52 || card_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got busy=%b rank=%0d left=%0d v=%b want 0 0 52 0", busy, card_rank, cards_left, card_valid);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_deal_basic();
    test_reject_range();
    test_exhaust();
    test_empty_deck();
    test_shuffle();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
